// File: rtl/mux_scan_ctrl_if.sv
// Scan controller bus: request/mask in, mux select and sampled value,
// snapshot out over a valid/ready handshake.
interface mux_scan_ctrl_if;
   logic       start;
   logic [7:0] mask;
   logic [2:0] sel;
   logic       y;
   logic       busy;
   logic [7:0] snap;
   logic       snap_valid;
   logic       snap_ready;

   // Controller side
   modport master (
      input  start, mask, y, snap_ready,
      output sel, busy, snap, snap_valid
   );

   // Requester / mux / downstream side
   modport slave (
      output start, mask, y, snap_ready,
      input  sel, busy, snap, snap_valid
   );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Steps an 8:1 mux select across the enabled channels in ascending order,
// waits SETTLE cycles per channel, samples y, and hands the assembled
// snapshot downstream with valid/ready.
module mux_scan_ctrl #(
   parameter int unsigned SETTLE = 1
) (
   input logic             clk,
   input logic             rst_n,
   mux_scan_ctrl_if.master bus
);

   typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

   localparam logic [3:0] SETTLE_C = 4'(SETTLE);

   state_t     state_q, state_d;
   logic [2:0] sel_q, sel_d;
   logic [3:0] cnt_q, cnt_d;
   logic [7:0] mask_q, mask_d;
   logic [7:0] shadow_q, shadow_d;
   logic [7:0] snap_q, snap_d;

   logic       first_hit, next_hit;
   logic [2:0] first_ch, next_ch;
   logic [7:0] shadow_upd;

   // Channel search: lowest enabled channel of the incoming mask, and the
   // lowest enabled channel above the current one in the latched mask.
   always_comb begin
      first_hit = 1'b0;
      first_ch  = '0;
      next_hit  = 1'b0;
      next_ch   = '0;
      for (int unsigned i = 8; i > 0; i--) begin
         if (bus.mask[3'(i - 1)]) begin
            first_hit = 1'b1;
            first_ch  = 3'(i - 1);
         end
         if (mask_q[3'(i - 1)] && ((i - 1) > 32'(sel_q))) begin
            next_hit = 1'b1;
            next_ch  = 3'(i - 1);
         end
      end
   end

   // Shadow with the current channel's sample merged in.
   always_comb begin
      shadow_upd        = shadow_q;
      shadow_upd[sel_q] = bus.y;
   end

   // Next-state and datapath update.
   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      cnt_d    = cnt_q;
      mask_d   = mask_q;
      shadow_d = shadow_q;
      snap_d   = snap_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               mask_d = bus.mask;
               if (first_hit) begin
                  state_d  = SCAN;
                  sel_d    = first_ch;
                  cnt_d    = SETTLE_C;
                  shadow_d = '0;
               end else begin
                  state_d = HOLD;
                  snap_d  = '0;
               end
            end
         end
         SCAN: begin
            if (cnt_q == 4'd1) begin
               shadow_d = shadow_upd;
               if (next_hit) begin
                  sel_d = next_ch;
                  cnt_d = SETTLE_C;
               end else begin
                  state_d = HOLD;
                  snap_d  = shadow_upd;
                  cnt_d   = '0;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         HOLD: begin
            if (bus.snap_ready) begin
               state_d = IDLE;
               sel_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            sel_d   = '0;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         sel_q    <= '0;
         cnt_q    <= '0;
         mask_q   <= '0;
         shadow_q <= '0;
         snap_q   <= '0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         cnt_q    <= cnt_d;
         mask_q   <= mask_d;
         shadow_q <= shadow_d;
         snap_q   <= snap_d;
      end
   end

   assign bus.sel        = sel_q;
   assign bus.busy       = (state_q != IDLE);
   assign bus.snap_valid = (state_q == HOLD);
   assign bus.snap       = snap_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: two instances (SETTLE=1 and SETTLE=3) share the
// stimulus; a channel-list model predicts every output each cycle.
module tb_mux_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] mask = '0;
   logic [7:0] data = '0;
   logic       snap_ready = 1'b0;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mux_scan_ctrl_if bus1 ();
   mux_scan_ctrl_if bus3 ();

   assign bus1.start      = start;
   assign bus1.mask       = mask;
   assign bus1.snap_ready = snap_ready;
   assign bus1.y          = data[bus1.sel];
   assign bus3.start      = start;
   assign bus3.mask       = mask;
   assign bus3.snap_ready = snap_ready;
   assign bus3.y          = data[bus3.sel];

   mux_scan_ctrl #(.SETTLE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
   mux_scan_ctrl #(.SETTLE(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

   logic [2:0] o_sel[2];
   logic       o_busy[2];
   logic       o_valid[2];
   logic [7:0] o_snap[2];
   assign o_sel[0]   = bus1.sel;
   assign o_busy[0]  = bus1.busy;
   assign o_valid[0] = bus1.snap_valid;
   assign o_snap[0]  = bus1.snap;
   assign o_sel[1]   = bus3.sel;
   assign o_busy[1]  = bus3.busy;
   assign o_valid[1] = bus3.snap_valid;
   assign o_snap[1]  = bus3.snap;

   int unsigned settle_of[2] = '{1, 3};

   task automatic check(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s[S=%0d] got=%0h want=%0h at %0t", nm, settle_of[i], act, exp, $time);
      end
   endtask

   // k-th (0-based) set bit of m, ascending
   function automatic int nth(input logic [7:0] m, input int k);
      int c = 0;
      for (int b = 0; b < 8; b++) begin
         if (m[b]) begin
            if (c == k) return b;
            c++;
         end
      end
      return 0;
   endfunction

   // Model: mode 0 idle, 1 scanning, 2 holding; t counts edges since accept.
   int         m_mode[2];
   int         m_t[2];
   logic [7:0] m_mask[2];
   logic [2:0] m_sel[2];
   logic       m_busy[2];
   logic       m_valid[2];
   logic [7:0] m_snap[2];
   logic [7:0] m_acc[2];
   logic       seen_rst = 1'b0;

   initial begin
      for (int i = 0; i < 2; i++) begin
         m_mode[i] = 0; m_t[i] = 0; m_mask[i] = '0; m_sel[i] = '0;
         m_busy[i] = 1'b0; m_valid[i] = 1'b0; m_snap[i] = '0; m_acc[i] = '0;
      end
   end

   always @(posedge clk) begin : model
      int mode, t, k, ch, n;
      logic [7:0] mk, sn, ac;
      logic [2:0] sl;
      logic bz, vl;
      if (!rst_n) seen_rst <= 1'b1;
      for (int i = 0; i < 2; i++) begin
         mode = m_mode[i]; t = m_t[i]; mk = m_mask[i]; sl = m_sel[i];
         bz = m_busy[i]; vl = m_valid[i]; sn = m_snap[i]; ac = m_acc[i];
         n = $countones(mk);
         if (!rst_n) begin
            mode = 0; t = 0; sl = '0; bz = 1'b0; vl = 1'b0; sn = '0; ac = '0;
         end else if (mode == 0) begin
            if (start) begin
               mk = mask;
               bz = 1'b1;
               if (mask == 8'h00) begin
                  mode = 2; vl = 1'b1; sn = '0;
               end else begin
                  mode = 1; t = 0; ac = '0; sl = 3'(nth(mask, 0));
               end
            end
         end else if (mode == 1) begin
            t++;
            if (t % int'(settle_of[i]) == 0) begin
               k = t / int'(settle_of[i]);
               ch = nth(mk, k - 1);
               ac[ch] = data[ch];
               if (k == n) begin
                  mode = 2; vl = 1'b1; sn = ac;
               end else begin
                  sl = 3'(nth(mk, k));
               end
            end
         end else begin
            if (snap_ready) begin
               mode = 0; vl = 1'b0; bz = 1'b0; sl = '0;
            end
         end
         m_mode[i] <= mode; m_t[i] <= t; m_mask[i] <= mk; m_sel[i] <= sl;
         m_busy[i] <= bz; m_valid[i] <= vl; m_snap[i] <= sn; m_acc[i] <= ac;
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (seen_rst) begin
         for (int i = 0; i < 2; i++) begin
            check("sel", i, 32'(o_sel[i]), 32'(m_sel[i]));
            check("busy", i, 32'(o_busy[i]), 32'(m_busy[i]));
            check("snap_valid", i, 32'(o_valid[i]), 32'(m_valid[i]));
            check("snap", i, 32'(o_snap[i]), 32'(m_snap[i]));
         end
      end
   end

   // One scan with hand-computed snapshot and valid-edge expectations.
   task automatic do_scan(input logic [7:0] m, input logic [7:0] d, input logic [7:0] exp, input int bp);
      int n, e;
      int ve[2];
      n = $countones(m);
      ve[0] = -1; ve[1] = -1;
      @(negedge clk);
      mask = m; data = d; start = 1'b1; snap_ready = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      if (n == 0) begin
         check("no_sel_activity", 0, 32'(o_sel[0]), 32'd0);
         check("no_sel_activity", 1, 32'(o_sel[1]), 32'd0);
      end
      e = 0;
      while (e < 200) begin
         for (int i = 0; i < 2; i++)
            if (o_valid[i] && ve[i] < 0) ve[i] = e;
         if (ve[0] >= 0 && ve[1] >= 0) break;
         @(posedge clk); #1;
         e++;
      end
      for (int i = 0; i < 2; i++) begin
         check("valid_edge", i, 32'(ve[i]), 32'(n * int'(settle_of[i])));
         check("snap_lit", i, 32'(o_snap[i]), 32'(exp));
      end
      repeat (bp) begin
         @(negedge clk);
         start = 1'($urandom); data = 8'($urandom);
         @(posedge clk); #1;
         for (int i = 0; i < 2; i++) begin
            check("bp_valid", i, 32'(o_valid[i]), 32'd1);
            check("bp_snap", i, 32'(o_snap[i]), 32'(exp));
         end
      end
      @(negedge clk);
      start = 1'b0; snap_ready = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
         check("xfer_valid", i, 32'(o_valid[i]), 32'd0);
         check("xfer_busy", i, 32'(o_busy[i]), 32'd0);
      end
      @(negedge clk);
      snap_ready = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         check("rst_sel", i, 32'(o_sel[i]), 32'd0);
         check("rst_busy", i, 32'(o_busy[i]), 32'd0);
         check("rst_valid", i, 32'(o_valid[i]), 32'd0);
         check("rst_snap", i, 32'(o_snap[i]), 32'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;

      // a..h = 0,1,1,1,0,0,1,0
      do_scan(8'hFF, 8'b0100_1110, 8'h4E, 0);
      do_scan(8'hA5, 8'hFF, 8'hA5, 0);
      do_scan(8'h00, 8'hFF, 8'h00, 0);
      do_scan(8'h81, 8'h01, 8'h01, 5);

      // Reset mid-scan discards everything
      @(negedge clk);
      mask = 8'hFF; data = 8'h3C; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
         check("mid_rst_sel", i, 32'(o_sel[i]), 32'd0);
         check("mid_rst_busy", i, 32'(o_busy[i]), 32'd0);
         check("mid_rst_valid", i, 32'(o_valid[i]), 32'd0);
         check("mid_rst_snap", i, 32'(o_snap[i]), 32'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      do_scan(8'hFF, 8'h5A, 8'h5A, 0);

      // Randomized traffic, checked by the model every cycle
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         rst_n      = ($urandom_range(0, 99) != 0);
         start      = ($urandom_range(0, 3) == 0);
         case ($urandom_range(0, 7))
            0:       mask = 8'h00;
            1:       mask = 8'hFF;
            default: mask = 8'($urandom);
         endcase
         data       = 8'($urandom);
         snap_ready = 1'($urandom);
      end
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
